// File: rtl/trig_multi_if.sv
// trig_multi_if: the bus between the ranging sequencer / echo capture side
// and the multi-channel trigger generator.
//   enable     start request; a rising edge starts one trigger
//   pulse_len  trigger high time in clk cycles (0 acts as 1)
//   holdoff    guard time after the pulse in clk cycles
//   ch_mask    per-channel participation in the round-robin rotation
//   sig        one-hot (or zero) trigger outputs
//   ch_idx     channel of the current or most recent trigger
//   ready      high only while idle
//   done       one-cycle pulse when a trigger sequence completes
//   err        one-cycle pulse when a start is rejected (ch_mask == 0)
//   auto_run   only with TRIG_MULTI_AUTO_EN: chain channels without new starts
// master = sequencer side, slave = trig_multi.
interface trig_multi_if #(
    parameter int CNT_LEN = 8,
    parameter int N_CH    = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic               enable;
    logic [CNT_LEN-1:0] pulse_len;
    logic [CNT_LEN-1:0] holdoff;
    logic [N_CH-1:0]    ch_mask;
    logic [N_CH-1:0]    sig;
    logic [CH_W-1:0]    ch_idx;
    logic               ready;
    logic               done;
    logic               err;
`ifdef TRIG_MULTI_AUTO_EN
    logic               auto_run;
`endif

    modport master (
`ifdef TRIG_MULTI_AUTO_EN
        output auto_run,
`endif
        output enable, pulse_len, holdoff, ch_mask,
        input  sig, ch_idx, ready, done, err
    );

    modport slave (
`ifdef TRIG_MULTI_AUTO_EN
        input  auto_run,
`endif
        input  enable, pulse_len, holdoff, ch_mask,
        output sig, ch_idx, ready, done, err
    );
endinterface

// File: rtl/trig_multi.sv
// trig_multi: round-robin trigger generator for N_CH ultrasonic sensors.
// Each rising edge of enable (seen while idle) fires one pulse of
// max(pulse_len,1) cycles on the next enabled channel after the last one
// used, followed by holdoff quiet cycles, then a one-cycle done.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   trig_multi_if.slave (enable, pulse_len, holdoff, ch_mask in;
//         sig, ch_idx, ready, done, err out)
// Optional macro TRIG_MULTI_AUTO_EN: adds bus.auto_run; while set, the end
// of a sequence immediately relaunches on the next channel with freshly
// sampled ch_mask/pulse_len/holdoff (done still pulses, ready stays low).
module trig_multi #(
    parameter int CNT_LEN = 8,
    parameter int N_CH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    trig_multi_if.slave  bus
);
    localparam int CH_W = $clog2(N_CH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               en_q;
    logic [CNT_LEN-1:0] cnt_q, cnt_d;
    logic [CNT_LEN-1:0] plen_q, plen_d;
    logic [CNT_LEN-1:0] hold_q, hold_d;
    logic [N_CH-1:0]    sig_q, sig_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic [CH_W-1:0]    idx_q, idx_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               start;
    logic               pulse_last, hold_last;
    logic               launch, finish;
    logic [CH_W-1:0]    nxt_ch, cand;

    assign start      = bus.enable && !en_q;
    // pulse_len of 0 behaves as 1: the first pulse cycle is also the last
    assign pulse_last = (plen_q == '0) || (cnt_q == plen_q - CNT_LEN'(1));
    assign hold_last  = (cnt_q == hold_q - CNT_LEN'(1));

    // Next set mask bit strictly after ptr_q, wrapping; scanning offsets
    // downward lets the smallest offset win. Offset N_CH lands on ptr_q
    // itself, which covers a single-bit mask reusing its channel.
    always_comb begin
        nxt_ch = ptr_q;
        cand   = ptr_q;
        for (int off = N_CH; off >= 1; off--) begin
            cand = CH_W'((int'(ptr_q) + off) % N_CH);
            if (bus.ch_mask[cand]) nxt_ch = cand;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        plen_d  = plen_q;
        hold_d  = hold_q;
        sig_d   = sig_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        launch  = 1'b0;
        finish  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (bus.ch_mask == '0) err_d  = 1'b1;
                    else                   launch = 1'b1;
                end
            end
            S_PULSE: begin
                cnt_d = cnt_q + CNT_LEN'(1);
                if (pulse_last) begin
                    sig_d = '0;
                    cnt_d = '0;
                    if (hold_q != '0) state_d = S_HOLD;
                    else              finish  = 1'b1;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CNT_LEN'(1);
                if (hold_last) finish = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef TRIG_MULTI_AUTO_EN
            // a zero mask here just ends the run quietly, no err
            if (bus.auto_run && (bus.ch_mask != '0)) launch = 1'b1;
`endif
        end

        if (launch) begin
            plen_d        = bus.pulse_len;
            hold_d        = bus.holdoff;
            ptr_d         = nxt_ch;
            idx_d         = nxt_ch;
            cnt_d         = '0;
            sig_d         = '0;
            sig_d[nxt_ch] = 1'b1;
            state_d       = S_PULSE;
        end

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            plen_q  <= '0;
            hold_q  <= '0;
            sig_q   <= '0;
            ptr_q   <= CH_W'(N_CH - 1);
            idx_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= bus.enable;
            cnt_q   <= cnt_d;
            plen_q  <= plen_d;
            hold_q  <= hold_d;
            sig_q   <= sig_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.sig    = sig_q;
    assign bus.ch_idx = idx_q;
    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule
